// File: rtl/program_sequencer.sv
// Multi-cycle sequencer: fetches instruction words from a synchronous ROM, decodes them and
// drives the X/Y/Z register commands plus an immediate for one EXEC cycle per instruction.
module program_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4,
  parameter int MAX_STEPS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              status,
  input  logic [2+DATA_W:0] imem_data,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [2:0]        Tx,
  output logic [2:0]        Ty,
  output logic [2:0]        Tz,
  output logic [2:0]        tula,
  output logic [DATA_W-1:0] value_out,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              timeout
);

  localparam int CNT_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

  localparam logic [2:0] T_HOLD   = 3'b000;
  localparam logic [2:0] T_LOAD   = 3'b001;
  localparam logic [2:0] T_SHIFTR = 3'b010;
  localparam logic [2:0] T_RESET  = 3'b100;

  localparam logic [2:0] OP_CLRLD   = 3'd0;
  localparam logic [2:0] OP_ADDLD   = 3'd1;
  localparam logic [2:0] OP_ADD     = 3'd2;
  localparam logic [2:0] OP_DIV2    = 3'd3;
  localparam logic [2:0] OP_DISPLAY = 3'd4;
  localparam logic [2:0] OP_JMP     = 3'd5;
  localparam logic [2:0] OP_HALT    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t                   state_q;
  logic [ADDR_W-1:0]        pc_q;
  logic [ADDR_W-1:0]        pc_d;
  logic [2+DATA_W:0]        ir_q;
  logic [CNT_W-1:0]         count_q;
  logic [2:0]               tx_q, ty_q, tz_q;
  logic [2:0]               tx_d, ty_d, tz_d;
  logic [DATA_W-1:0]        value_q;
  logic                     busy_q, done_q, ovf_q, timeout_q;

  logic [2:0]               dec_op, ir_op;
  logic [DATA_W-1:0]        dec_val, ir_val;
  logic [ADDR_W+DATA_W-1:0] jmp_ext;
  logic                     last_step;
  logic                     ovf_op;

  assign dec_op  = imem_data[2+DATA_W:DATA_W];
  assign dec_val = imem_data[DATA_W-1:0];
  assign ir_op   = ir_q[2+DATA_W:DATA_W];
  assign ir_val  = ir_q[DATA_W-1:0];

  // Jump target is zero-extended then truncated, so any DATA_W/ADDR_W ratio works.
  assign jmp_ext   = {{ADDR_W{1'b0}}, ir_val};
  assign pc_d      = (ir_op == OP_JMP) ? jmp_ext[ADDR_W-1:0] : pc_q + 1'b1;
  assign last_step = (count_q == CNT_W'(MAX_STEPS - 1));
  assign ovf_op    = (ir_op == OP_ADDLD) || (ir_op == OP_ADD);

  always_comb begin
    tx_d = T_HOLD;
    ty_d = T_HOLD;
    tz_d = T_HOLD;
    case (dec_op)
      OP_CLRLD:   begin tx_d = T_LOAD; ty_d = T_RESET; tz_d = T_RESET; end
      OP_ADDLD:   begin tx_d = T_LOAD; ty_d = T_LOAD; end
      OP_ADD:     ty_d = T_LOAD;
      OP_DIV2:    ty_d = T_SHIFTR;
      OP_DISPLAY: tz_d = T_LOAD;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      count_q   <= '0;
      tx_q      <= T_HOLD;
      ty_q      <= T_HOLD;
      tz_q      <= T_HOLD;
      value_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!pause) state_q <= S_DECODE;
        end
        S_DECODE: begin
          ir_q <= imem_data;
          if (dec_op == OP_HALT) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_EXEC;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tz_q    <= tz_d;
            value_q <= dec_val;
          end
        end
        S_EXEC: begin
          tx_q    <= T_HOLD;
          ty_q    <= T_HOLD;
          tz_q    <= T_HOLD;
          pc_q    <= pc_d;
          count_q <= count_q + 1'b1;
          if (status && ovf_op) ovf_q <= 1'b1;
          // Watchdog: the step just executed was the last one allowed.
          if (last_step) begin
            state_q   <= S_DONE;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign Tx        = tx_q;
  assign Ty        = ty_q;
  assign Tz        = tz_q;
  assign tula      = 3'b000;
  assign value_out = value_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: a directed program table plus random programs, each checked
// cycle by cycle against an instruction-level model that expands programs into per-cycle outputs.
module tb_program_sequencer;
  localparam int AW = 3;
  localparam int DW = 4;
  localparam int MS = 12;
  localparam int IW = 3 + DW;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC = 256;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SHR = 3'b010, RSTC = 3'b100;
  localparam logic [2:0] CLRLD = 3'd0, ADDLD = 3'd1, ADD = 3'd2, DIV2 = 3'd3;
  localparam logic [2:0] DISP = 3'd4, JMP = 3'd5, NOP = 3'd6, HALT = 3'd7;

  logic          clk = 1'b0;
  logic          rst, start, pause, status;
  logic [IW-1:0] imem_data;
  logic [AW-1:0] imem_addr;
  logic [2:0]    tx, ty, tz, tula;
  logic [DW-1:0] value_out;
  logic          busy, done, ovf, timeout;

  program_sequencer #(.ADDR_W(AW), .DATA_W(DW), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .status(status),
    .imem_data(imem_data), .imem_addr(imem_addr),
    .Tx(tx), .Ty(ty), .Tz(tz), .tula(tula), .value_out(value_out),
    .busy(busy), .done(done), .ovf(ovf), .timeout(timeout)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] rom [DEPTH];
  always @(posedge clk) imem_data <= rom[imem_addr];

  typedef struct {
    logic          busy, done, ovf, tmo;
    logic [AW-1:0] pc;
    logic [2:0]    tx, ty, tz;
    logic [DW-1:0] val;
  } exp_t;

  typedef logic [DEPTH-1:0][IW-1:0] img_t;
  typedef struct {
    img_t img;
    int   p_from, p_len;
    bit   stat1, rs;
    int   e_done;
    bit   e_to, e_ovf;
    int   e_pc;
  } vec_t;

  exp_t exp_q[$];
  bit   pause_arr[MAXC];
  bit   stat_arr[MAXC];
  int   checks = 0;
  int   failures = 0;

  // Architectural state carried between runs by the model.
  logic [AW-1:0] m_pc = '0;
  logic [DW-1:0] m_val = '0;
  logic          m_ovf = 1'b0, m_tmo = 1'b0;

  function automatic logic [IW-1:0] ins(input logic [2:0] op, input int v);
    return {op, DW'(v)};
  endfunction

  function automatic img_t prog(input logic [IW-1:0] a0, a1, a2, a3, rest);
    img_t r;
    for (int i = 0; i < DEPTH; i++) r[i] = rest;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  function automatic void push(input bit b, input bit d, input logic [2:0] x, y, z);
    exp_t e;
    e.busy = b; e.done = d; e.ovf = m_ovf; e.tmo = m_tmo; e.pc = m_pc;
    e.tx = x; e.ty = y; e.tz = z; e.val = m_val;
    exp_q.push_back(e);
  endfunction

  // Expand the current ROM into expected per-cycle outputs; index 0 is the start cycle.
  function automatic void build_model();
    int steps = 0;
    bit fin = 1'b0;
    logic [2:0] op, x, y, z;
    logic [DW-1:0] v;
    exp_q.delete();
    push(1'b0, 1'b0, HOLD, HOLD, HOLD);
    m_pc = '0; m_ovf = 1'b0; m_tmo = 1'b0;
    while (!fin) begin
      push(1'b1, 1'b0, HOLD, HOLD, HOLD);
      while (pause_arr[exp_q.size() - 1] && exp_q.size() < MAXC - 8) push(1'b1, 1'b0, HOLD, HOLD, HOLD);
      push(1'b1, 1'b0, HOLD, HOLD, HOLD);
      op = rom[m_pc][IW-1:DW];
      v  = rom[m_pc][DW-1:0];
      if (op == HALT) begin
        push(1'b0, 1'b1, HOLD, HOLD, HOLD);
        fin = 1'b1;
      end else begin
        x = HOLD; y = HOLD; z = HOLD;
        case (op)
          CLRLD:   begin x = LOAD; y = RSTC; z = RSTC; end
          ADDLD:   begin x = LOAD; y = LOAD; end
          ADD:     y = LOAD;
          DIV2:    y = SHR;
          DISP:    z = LOAD;
          default: ;
        endcase
        m_val = v;
        push(1'b1, 1'b0, x, y, z);
        if ((op == ADDLD || op == ADD) && stat_arr[exp_q.size() - 1]) m_ovf = 1'b1;
        if (op == JMP) m_pc = AW'(int'(v) % DEPTH);
        else           m_pc = AW'((int'(m_pc) + 1) % DEPTH);
        steps++;
        if (steps == MS) begin
          m_tmo = 1'b1;
          push(1'b0, 1'b1, HOLD, HOLD, HOLD);
          fin = 1'b1;
        end
      end
    end
    push(1'b0, 1'b0, HOLD, HOLD, HOLD);
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, c, act, req);
    end
  endtask

  task automatic cmp(input string tag, input int c, input exp_t e);
    chk({tag, ".busy"}, c, 32'(busy), 32'(e.busy));
    chk({tag, ".done"}, c, 32'(done), 32'(e.done));
    chk({tag, ".ovf"}, c, 32'(ovf), 32'(e.ovf));
    chk({tag, ".timeout"}, c, 32'(timeout), 32'(e.tmo));
    chk({tag, ".imem_addr"}, c, 32'(imem_addr), 32'(e.pc));
    chk({tag, ".Tx"}, c, 32'(tx), 32'(e.tx));
    chk({tag, ".Ty"}, c, 32'(ty), 32'(e.ty));
    chk({tag, ".Tz"}, c, 32'(tz), 32'(e.tz));
    chk({tag, ".tula"}, c, 32'(tula), 32'(HOLD));
    chk({tag, ".value_out"}, c, 32'(value_out), 32'(e.val));
  endtask

  task automatic run_program(input string name, input bit rs, output int done_cyc,
                             output logic to_d, output logic ovf_d, output logic [AW-1:0] pc_d);
    int n;
    build_model();
    n = exp_q.size();
    done_cyc = -1; to_d = 1'b0; ovf_d = 1'b0; pc_d = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (c == 0)              start = 1'b1;
      else if (rs && c < n - 1) start = 1'($urandom_range(0, 1));
      else                     start = 1'b0;
      pause  = pause_arr[c];
      status = stat_arr[c];
      @(negedge clk);
      cmp(name, c, exp_q[c]);
      if (done === 1'b1) begin
        done_cyc = c; to_d = timeout; ovf_d = ovf; pc_d = imem_addr;
      end
    end
    $display("run %s cycles=%0d done_cycle=%0d timeout=%0b ovf=%0b pc=%0d",
             name, n, done_cyc, to_d, ovf_d, pc_d);
  endtask

  vec_t tbl[9];
  exp_t e0;
  int dc;
  logic dto, dovf;
  logic [AW-1:0] dpc;

  initial begin
    tbl[0] = '{prog(ins(CLRLD, 5), ins(ADDLD, 3), ins(DISP, 0), ins(HALT, 0), ins(HALT, 0)), 0, 0, 0, 0, 12, 0, 0, 3};
    tbl[1] = '{prog(ins(JMP, 0), ins(JMP, 0), ins(JMP, 0), ins(JMP, 0), ins(JMP, 0)), 0, 0, 0, 0, 37, 1, 0, 0};
    tbl[2] = '{prog(ins(NOP, 0), ins(NOP, 1), ins(NOP, 2), ins(NOP, 3), ins(NOP, 4)), 0, 0, 0, 1, 37, 1, 0, 4};
    tbl[3] = '{prog(ins(JMP, 12), ins(NOP, 0), ins(NOP, 0), ins(NOP, 0), ins(HALT, 0)), 0, 0, 0, 0, 6, 0, 0, 4};
    tbl[4] = '{prog(ins(NOP, 0), ins(NOP, 0), ins(DISP, 9), ins(HALT, 0), ins(HALT, 0)), 7, 5, 0, 0, 17, 0, 0, 3};
    tbl[5] = '{prog(ins(ADD, 1), ins(HALT, 0), ins(HALT, 0), ins(HALT, 0), ins(HALT, 0)), 0, 0, 1, 0, 6, 0, 1, 1};
    tbl[6] = '{prog(ins(ADD, 1), ins(HALT, 0), ins(HALT, 0), ins(HALT, 0), ins(HALT, 0)), 0, 0, 0, 1, 6, 0, 0, 1};
    tbl[7] = '{prog(ins(HALT, 0), ins(NOP, 0), ins(NOP, 0), ins(NOP, 0), ins(NOP, 0)), 0, 0, 0, 0, 3, 0, 0, 0};
    tbl[8] = '{prog(ins(DIV2, 2), ins(ADDLD, 1), ins(HALT, 0), ins(HALT, 0), ins(HALT, 0)), 0, 0, 1, 0, 9, 0, 1, 2};

    e0 = '{1'b0, 1'b0, 1'b0, 1'b0, '0, HOLD, HOLD, HOLD, '0};
    for (int a = 0; a < DEPTH; a++) rom[a] = ins(HALT, 0);
    rst = 1'b1; start = 1'b0; pause = 1'b0; status = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmp("reset", c, e0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int t = 0; t < 9; t++) begin
      for (int a = 0; a < DEPTH; a++) rom[a] = tbl[t].img[a];
      for (int c = 0; c < MAXC; c++) begin
        pause_arr[c] = (c >= tbl[t].p_from) && (c < tbl[t].p_from + tbl[t].p_len);
        stat_arr[c]  = tbl[t].stat1;
      end
      run_program($sformatf("vec%0d", t), tbl[t].rs, dc, dto, dovf, dpc);
      chk("vec.done_cycle", t, 32'(dc), 32'(tbl[t].e_done));
      chk("vec.timeout", t, 32'(dto), 32'(tbl[t].e_to));
      chk("vec.ovf", t, 32'(dovf), 32'(tbl[t].e_ovf));
      chk("vec.pc", t, 32'(dpc), 32'(tbl[t].e_pc));
    end

    for (int r = 0; r < 25; r++) begin
      for (int a = 0; a < DEPTH; a++) rom[a] = IW'($urandom_range(0, (1 << IW) - 1));
      for (int c = 0; c < MAXC; c++) begin
        pause_arr[c] = (c < MAXC - 60) && ($urandom_range(0, 4) == 0);
        stat_arr[c]  = 1'($urandom_range(0, 1));
      end
      run_program($sformatf("rand%0d", r), 1'b1, dc, dto, dovf, dpc);
      chk("rand.done_seen", r, 32'(dc > 0), 32'd1);
    end

    // Reset mid-EXEC of ADDLD with status high: everything clears, no done pulse.
    rom[0] = ins(ADDLD, 7);
    for (int a = 1; a < DEPTH; a++) rom[a] = ins(HALT, 0);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      start  = (c == 0);
      status = (c == 3);
      rst    = (c == 3);
      pause  = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        chk("rst.exec_Tx", c, 32'(tx), 32'(LOAD));
        chk("rst.exec_val", c, 32'(value_out), 32'd7);
      end
      if (c >= 4) cmp("rst", c, e0);
    end
    $display("run rst_mid_exec checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
